// File: rtl/ofm_buf_pkg.sv
// rtl/ofm_buf_pkg.sv - shared types, default sizes and word-width helper for the OFM ping-pong buffer
package ofm_buf_pkg;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2,
        DRAIN = 2'd3
    } bank_state_t;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_LANES    = 4;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_DEPTH    = 172;

    function automatic int word_width(input int channels, input int lanes, input int data_w);
        return channels * lanes * data_w;
    endfunction

endpackage

// File: rtl/ofm_bank.sv
// rtl/ofm_bank.sv - one OFM bank: single write port, synchronous read, contents not reset
module ofm_bank
    import ofm_buf_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEF_DEPTH),
    parameter int WORD_W = word_width(DEF_CHANNELS, DEF_LANES, DEF_DATA_W)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Callers only enable ports with in-range addresses.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ofm_pingpong_buffer.sv
// rtl/ofm_pingpong_buffer.sv - double-banked OFM store with bank ownership tracking; OFM_ZERO_PAD_EN enables zero-padded out-of-range reads
module ofm_pingpong_buffer
    import ofm_buf_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int LANES    = DEF_LANES,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           wr_en,
    input  logic [ADDR_W-1:0]                              wr_addr,
    input  logic [word_width(CHANNELS, LANES, DATA_W)-1:0] wr_data,
    input  logic                                           wr_done,
    output logic                                           wr_ready,
    input  logic                                           rd_en,
    input  logic [ADDR_W-1:0]                              rd_addr,
    output logic [word_width(CHANNELS, LANES, DATA_W)-1:0] rd_data,
    output logic                                           rd_valid,
    output logic                                           rd_avail,
    input  logic                                           rd_release,
    output logic [1:0]                                     occupancy,
    output logic                                           err
);

    localparam int WORD_W = word_width(CHANNELS, LANES, DATA_W);
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    bank_state_t       state_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic              rd_valid_q;
    logic              rd_sel_q;
    logic              rd_zero_q;
    logic              err_q;

    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_accept;
    logic              rd_accept;
    logic [1:0]        bank_busy;
    logic [WORD_W-1:0] bank_rdata [2];

    always_comb begin
        wr_ready    = (state_q[wr_ptr_q] == FREE) || (state_q[wr_ptr_q] == FILL);
        rd_avail    = (state_q[rd_ptr_q] == READY) || (state_q[rd_ptr_q] == DRAIN);
        wr_in_range = {1'b0, wr_addr} < DEPTH_EXT;
        rd_in_range = {1'b0, rd_addr} < DEPTH_EXT;
        wr_accept   = wr_en && wr_ready && wr_in_range;
        rd_accept   = rd_en && rd_avail;
        for (int b = 0; b < 2; b++) begin
            bank_busy[b] = (state_q[b] == READY) || (state_q[b] == DRAIN);
        end
    end

    // Write side touches only state[wr_ptr] in FREE/FILL and read side only
    // state[rd_ptr] in READY/DRAIN, so the two never update the same bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q[0] <= FREE;
            state_q[1] <= FREE;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_sel_q   <= 1'b0;
            rd_zero_q  <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;

            if (wr_accept && (state_q[wr_ptr_q] == FREE)) begin
                state_q[wr_ptr_q] <= FILL;
            end
            if (wr_done && wr_ready) begin
                state_q[wr_ptr_q] <= READY;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (((wr_en || wr_done) && !wr_ready) || (wr_en && wr_ready && !wr_in_range)) begin
                err_q <= 1'b1;
            end

            if (rd_accept) begin
                if (rd_in_range) begin
                    rd_valid_q <= 1'b1;
                    rd_sel_q   <= rd_ptr_q;
                    rd_zero_q  <= 1'b0;
                    if (state_q[rd_ptr_q] == READY) begin
                        state_q[rd_ptr_q] <= DRAIN;
                    end
                end else begin
`ifdef OFM_ZERO_PAD_EN
                    rd_valid_q <= 1'b1;
                    rd_zero_q  <= 1'b1;
                    if (state_q[rd_ptr_q] == READY) begin
                        state_q[rd_ptr_q] <= DRAIN;
                    end
`else
                    err_q <= 1'b1;
`endif
                end
            end
            if (rd_release && rd_avail) begin
                state_q[rd_ptr_q] <= FREE;
                rd_ptr_q          <= ~rd_ptr_q;
            end
            if ((rd_en || rd_release) && !rd_avail) begin
                err_q <= 1'b1;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        ofm_bank #(
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W),
            .WORD_W (WORD_W)
        ) u_bank (
            .clk_i   (clk),
            .we_i    (wr_accept && (wr_ptr_q == 1'(b))),
            .waddr_i (wr_addr),
            .wdata_i (wr_data),
            .re_i    (rd_accept && rd_in_range && (rd_ptr_q == 1'(b))),
            .raddr_i (rd_addr),
            .rdata_o (bank_rdata[b])
        );
    end

    // Bank output registers only change on their own reads, so the mux holds the last word.
    always_comb begin
        rd_data = rd_zero_q ? '0 : bank_rdata[rd_sel_q];
    end

    assign rd_valid  = rd_valid_q;
    assign err       = err_q;
    assign occupancy = 2'(bank_busy[0]) + 2'(bank_busy[1]);

endmodule
